// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding and hazard detection for the Balotelli pipeline.
//   Each read port resolves its operand from the youngest matching write
//   stage, else from the long-latency completion bus, else from the
//   register file. A per-register scoreboard tracks outstanding
//   long-latency writes, and a stall is raised when an operand cannot be
//   produced this cycle.
//
// Ports
//   Clk, Rst            clock, synchronous active-high reset
//   StgRd*In            per-stage write data/dest/enable/data-final flag
//   Rs*In / RsDataOut   source read ports and resolved operands
//   LongIssue*In        long-latency issue from ID (ignored while stalled)
//   LongDone*In         long-latency completion (bypassed same cycle)
//   StallOut            hold IF/ID, bubble into Ex
//   PendingOut          scoreboard bits (debug)
//   StallCntOut         saturating count of stall cycles
module fwd_hazard_unit #(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 5,
  parameter int NUM_RS  = 2,
  parameter int NUM_STG = 3,
  parameter int CNT_W   = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_STG*DATA_W-1:0]   StgRdDataIn,
  input  logic [NUM_STG*REG_AW-1:0]   StgRdAddrIn,
  input  logic [NUM_STG-1:0]          StgRdWeIn,
  input  logic [NUM_STG-1:0]          StgRdValidIn,
  input  logic [NUM_RS*REG_AW-1:0]    RsAddrIn,
  input  logic [NUM_RS-1:0]           RsReEnIn,
  input  logic [NUM_RS*DATA_W-1:0]    RsRegFileDataIn,
  output logic [NUM_RS*DATA_W-1:0]    RsDataOut,
  input  logic                        LongIssueIn,
  input  logic [REG_AW-1:0]           LongIssueAddrIn,
  input  logic                        LongDoneIn,
  input  logic [REG_AW-1:0]           LongDoneAddrIn,
  input  logic [DATA_W-1:0]           LongDoneDataIn,
  output logic                        StallOut,
  output logic [(1<<REG_AW)-1:0]      PendingOut,
  output logic [CNT_W-1:0]            StallCntOut
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   r_pend;
  logic [NREG-1:0]   w_pend_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_RS-1:0] w_haz;
  logic              w_stall;

  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    logic [REG_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_rf;
    logic              w_act;
    logic [DATA_W-1:0] l_data;
    logic              l_haz;
    logic              l_hit;
    logic              l_vld;

    assign w_addr = RsAddrIn[p*REG_AW +: REG_AW];
    assign w_rf   = RsRegFileDataIn[p*DATA_W +: DATA_W];
    assign w_act  = RsReEnIn[p] && (w_addr != '0);

    always_comb begin
      l_data = w_rf;
      l_haz  = 1'b0;
      l_hit  = 1'b0;
      l_vld  = 1'b1;
      // Walk oldest to youngest so the youngest match is the last one kept.
      for (int s = NUM_STG - 1; s >= 0; s--) begin
        if (StgRdWeIn[s] && (StgRdAddrIn[s*REG_AW +: REG_AW] == w_addr)) begin
          l_hit  = 1'b1;
          l_vld  = StgRdValidIn[s];
          l_data = StgRdDataIn[s*DATA_W +: DATA_W];
        end
      end
      if (!w_act) begin
        l_data = w_rf;
      end else if (l_hit) begin
        l_haz = !l_vld;
      end else if (LongDoneIn && (LongDoneAddrIn == w_addr)) begin
        l_data = LongDoneDataIn;
      end else begin
        l_data = w_rf;
        l_haz  = r_pend[w_addr];
      end
    end

    assign w_haz[p] = l_haz;
    assign RsDataOut[p*DATA_W +: DATA_W] = l_data;
  end

  assign w_stall = (|w_haz) && !Rst;
  assign StallOut = w_stall;

  // Issue is applied after done so a same-cycle reissue keeps the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (LongDoneIn) w_pend_nxt[LongDoneAddrIn] = 1'b0;
    if (LongIssueIn && !w_stall && (LongIssueAddrIn != '0))
      w_pend_nxt[LongIssueAddrIn] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_stall && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign PendingOut  = r_pend;
  assign StallCntOut = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int NRS  = 2;
  localparam int NSTG = 3;
  localparam int CW   = 4;
  localparam int NREG = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  // Unpacked stimulus, packed onto the flat DUT buses below.
  logic [DW-1:0] sd [NSTG];
  logic [AW-1:0] sa [NSTG];
  logic          swe[NSTG];
  logic          svl[NSTG];
  logic [AW-1:0] ra [NRS];
  logic          ren[NRS];
  logic [DW-1:0] rf [NRS];
  logic          iss, dn;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] ddata;

  logic [NSTG*DW-1:0] stg_data;
  logic [NSTG*AW-1:0] stg_addr;
  logic [NSTG-1:0]    stg_we, stg_vl;
  logic [NRS*AW-1:0]  rs_addr;
  logic [NRS-1:0]     rs_en;
  logic [NRS*DW-1:0]  rs_rf, rs_out;
  logic               stall;
  logic [NREG-1:0]    pend;
  logic [CW-1:0]      cnt;

  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      stg_data[s*DW +: DW] = sd[s];
      stg_addr[s*AW +: AW] = sa[s];
      stg_we[s] = swe[s];
      stg_vl[s] = svl[s];
    end
    for (int p = 0; p < NRS; p++) begin
      rs_addr[p*AW +: AW] = ra[p];
      rs_en[p] = ren[p];
      rs_rf[p*DW +: DW] = rf[p];
    end
  end

  fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_RS(NRS), .NUM_STG(NSTG), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .StgRdDataIn(stg_data), .StgRdAddrIn(stg_addr), .StgRdWeIn(stg_we), .StgRdValidIn(stg_vl),
    .RsAddrIn(rs_addr), .RsReEnIn(rs_en), .RsRegFileDataIn(rs_rf), .RsDataOut(rs_out),
    .LongIssueIn(iss), .LongIssueAddrIn(iaddr),
    .LongDoneIn(dn), .LongDoneAddrIn(daddr), .LongDoneDataIn(ddata),
    .StallOut(stall), .PendingOut(pend), .StallCntOut(cnt));

  typedef struct {
    logic [DW-1:0]   d [NRS];
    logic            stall;
    logic [NREG-1:0] pend;
    logic [CW-1:0]   cnt;
  } exp_t;
  exp_t q[$];

  // Reference model state: which registers await a long result, stall count.
  bit mpend[NREG];
  int mcnt;
  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Predict this cycle's outputs from current inputs, then advance the model.
  task automatic expect_and_advance();
    exp_t e;
    bit any_haz = 0;
    for (int p = 0; p < NRS; p++) begin
      int found = -1;
      e.d[p] = rf[p];
      if (ren[p] && ra[p] != 0) begin
        for (int s = 0; s < NSTG; s++)
          if (swe[s] && sa[s] == ra[p]) begin found = s; break; end
        if (found >= 0) begin
          e.d[p] = sd[found];
          if (!svl[found]) any_haz = 1;
        end else if (dn && daddr == ra[p]) begin
          e.d[p] = ddata;
        end else if (mpend[ra[p]]) begin
          any_haz = 1;
        end
      end
    end
    e.stall = any_haz && !Rst;
    for (int r = 0; r < NREG; r++) e.pend[r] = mpend[r];
    e.cnt = CW'(mcnt);
    q.push_back(e);
    if (Rst) begin
      for (int r = 0; r < NREG; r++) mpend[r] = 0;
      mcnt = 0;
    end else begin
      if (dn) mpend[daddr] = 0;
      if (iss && !e.stall && iaddr != 0) mpend[iaddr] = 1;
      if (e.stall && mcnt < CMAX) mcnt++;
    end
  endtask

  task automatic tick();
    expect_and_advance();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    for (int s = 0; s < NSTG; s++) begin sd[s] = '0; sa[s] = '0; swe[s] = 0; svl[s] = 1; end
    for (int p = 0; p < NRS; p++) begin ra[p] = '0; ren[p] = 0; rf[p] = '0; end
    iss = 0; dn = 0; iaddr = '0; daddr = '0; ddata = '0; Rst = 0;
  endtask

  // Monitor: outputs are combinational/registered every cycle; compare mid-cycle.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("rs0_data", rs_out[0 +: DW], e.d[0]);
      check("rs1_data", rs_out[DW +: DW], e.d[1]);
      check("stall", DW'(stall), DW'(e.stall));
      check("pending", DW'(pend), DW'(e.pend));
      check("stall_cnt", DW'(cnt), DW'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  function automatic logic [AW-1:0] raddr();
    int unsigned k = $urandom_range(0, 5);
    return (k == 0) ? AW'(0) : AW'(k + 2);
  endfunction

  initial begin
    idle();
    Rst = 1;
    for (int r = 0; r < NREG; r++) mpend[r] = 0;
    mcnt = 0;
    @(posedge Clk); #1;
    tick(); tick();
    idle();

    // Youngest stage wins; then older stage once stage0 drops.
    ra[0] = 5; ren[0] = 1; rf[0] = 64'h55;
    sa[0] = 5; sd[0] = 64'hA; swe[0] = 1;
    sa[2] = 5; sd[2] = 64'hC; swe[2] = 1;
    tick();
    swe[0] = 0; tick();
    idle();

    // x0 never forwarded.
    sa[0] = 0; sd[0] = 64'hFF; swe[0] = 1; ra[0] = 0; ren[0] = 1; rf[0] = 0;
    tick();
    idle();

    // Load-use: three stall cycles then data becomes final.
    sa[0] = 7; sd[0] = 64'h77; swe[0] = 1; svl[0] = 0; ra[1] = 7; ren[1] = 1;
    tick(); tick(); tick();
    svl[0] = 1; tick();
    idle();

    // Scoreboard: issue x9, four stalled reads, done bypass, bit clear.
    iss = 1; iaddr = 9; tick();
    iss = 0; ra[0] = 9; ren[0] = 1;
    for (int i = 0; i < 4; i++) tick();
    dn = 1; daddr = 9; ddata = 64'h1234; tick();
    dn = 0; tick();
    idle();

    // Set/clear collision on x3: set wins.
    iss = 1; iaddr = 3; tick();
    dn = 1; daddr = 3; ddata = 64'h33; tick();
    idle(); tick();
    ra[0] = 3; ren[0] = 1; tick();
    idle();

    // Reset with x4 pending discards everything; late done is a bypass.
    iss = 1; iaddr = 4; tick();
    idle(); Rst = 1; ra[0] = 4; ren[0] = 1; tick();
    Rst = 0; tick();
    dn = 1; daddr = 4; ddata = 64'h44; tick();
    idle();

    // Counter saturation: 20 load-use stall cycles.
    sa[1] = 6; swe[1] = 1; svl[1] = 0; ra[0] = 6; ren[0] = 1;
    for (int i = 0; i < 20; i++) tick();
    idle(); Rst = 1; tick();
    idle();

    // Random traffic with a small register pool to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      for (int s = 0; s < NSTG; s++) begin
        sd[s] = {$urandom, $urandom}; sa[s] = raddr();
        swe[s] = ($urandom_range(0, 2) == 0); svl[s] = ($urandom_range(0, 4) != 0);
      end
      for (int p = 0; p < NRS; p++) begin
        ra[p] = raddr(); ren[p] = ($urandom_range(0, 3) != 0); rf[p] = {$urandom, $urandom};
      end
      iss = ($urandom_range(0, 3) == 0); iaddr = raddr();
      dn = ($urandom_range(0, 3) == 0); daddr = raddr(); ddata = {$urandom, $urandom};
      Rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();

    @(negedge Clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand forwarding and hazard unit for the Balotelli pipeline. It feeds NUM_RS register-read ports from NUM_STG in-flight write stages or from a long-latency completion bus, and falls back to the register file otherwise. A per-register scoreboard tracks outstanding long-latency writes (load miss, mul/div). It raises a stall when an operand is not yet producible: a load-use hit in a stage whose data is not valid, or a pending scoreboard entry. x0 is never forwarded and never stalls.

## Interface
- DATA_W, 64, operand width
- REG_AW, 5, register address width (scoreboard depth 2^REG_AW)
- NUM_RS, 2, read ports (stride DATA_W / REG_AW in flattened buses)
- NUM_STG, 3, forwarding stages; index 0 = youngest (Ex), NUM_STG-1 = oldest (Wb)
- CNT_W, 32, stall counter width
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- StgRdDataIn  in  NUM_STG*DATA_W  per-stage write data
- StgRdAddrIn  in  NUM_STG*REG_AW  per-stage destination
- StgRdWeIn  in  NUM_STG  per-stage write enable
- StgRdValidIn  in  NUM_STG  stage data is final (0 = load result not yet available)
- RsAddrIn  in  NUM_RS*REG_AW  source addresses
- RsReEnIn  in  NUM_RS  source read enables
- RsRegFileDataIn  in  NUM_RS*DATA_W  register-file read data
- RsDataOut  out  NUM_RS*DATA_W  resolved operands
- LongIssueIn  in  1  ID issues a long-latency op this cycle
- LongIssueAddrIn  in  REG_AW  its destination
- LongDoneIn  in  1  long-latency result returns this cycle
- LongDoneAddrIn  in  REG_AW  returning destination
- LongDoneDataIn  in  DATA_W  returning data
- StallOut  out  1  hold IF/ID, bubble into Ex
- PendingOut  out  2^REG_AW  scoreboard bits (debug)
- StallCntOut  out  CNT_W  saturating count of stall cycles

## Operation
- Match for port p, stage s: StgRdWeIn[s] && StgRdAddrIn[s]==RsAddrIn[p] && RsReEnIn[p] && RsAddrIn[p]!=0.
- Operand source priority per port:
  - youngest matching stage (lowest s);
  - else LongDoneIn with equal, nonzero address;
  - else RsRegFileDataIn.
- RsAddrIn[p]==0 or RsReEnIn[p]==0: output RsRegFileDataIn unchanged, no stall contribution.
- Hazard per port:
  - selected stage has StgRdValidIn[s]==0; or
  - no stage matches, Pending[RsAddrIn[p]]==1 and no same-cycle LongDone for that address.
- StallOut = OR of per-port hazards; forced 0 while Rst=1.
- Scoreboard next state, evaluated per register:
  - Set when LongIssueIn && !StallOut && LongIssueAddrIn!=0.
  - Clear when LongDoneIn hits that address.
  - Set and clear on the same register in one cycle: set wins, since the newer issue supersedes.
  - Pending[0] is hard-wired 0.
- LongIssueIn while StallOut=1 is ignored. ID re-presents the op.
- LongDoneIn to a non-pending register: treated as plain bypass, no error.
- StallCntOut increments each cycle StallOut=1 and saturates at all-ones.

## Timing
- Forwarding mux and StallOut are combinational, same cycle as inputs.
- A scoreboard set is visible to hazard detection from cycle N+1 after issue at N.
- A done at N is bypassed at N, and the bit is clear from N+1.
- Reset, synchronous: Pending all 0, StallCntOut 0. During Rst, StallOut=0 and RsDataOut follows the mux with an empty scoreboard.
- Rst asserted mid-operation discards all outstanding entries. Late LongDone after reset is harmless bypass.
- No internal pipeline registers on the data path: latency 0 for operands, 1 for scoreboard state.

## Test plan
- Priority: Rs1=x5, stage0 writes x5=0xA, stage2 writes x5=0xC, all valid -> RsDataOut[0]=0xA, StallOut=0. Drop stage0 We -> 0xC.
- x0 guard: stage0 writes x0=0xFF, RsAddr=0, regfile data 0 -> RsDataOut=0, StallOut=0.
- Load-use: stage0 writes x7, StgRdValidIn[0]=0, Rs2=x7 -> StallOut=1, StallCntOut +1 per cycle. Valid=1 next cycle -> operand = stage0 data, StallOut=0.
- Scoreboard stall:
  - LongIssue x9 at N; Rs1=x9 at N+1..N+4 -> StallOut=1.
  - LongDone x9=0x1234 at N+5 -> RsDataOut=0x1234, StallOut=0 that cycle; PendingOut[9]=0 at N+6.
- Set/clear collision: x3 pending; LongIssue x3 and LongDone x3 in the same cycle -> PendingOut[3]=1 next cycle.
- Reset/saturation:
  - Rst with x4 pending -> PendingOut=0 and StallCntOut=0 next cycle.
  - CNT_W=4 with 20 stall cycles -> StallCntOut holds 0xF.
